// File: rtl/fir_stream_engine.sv
// fir_stream_engine: N-tap signed FIR filter.
// Coefficients and control are reached over AXI4-Lite. Samples arrive on an
// AXI-Stream slave and filtered results leave on an AXI-Stream master.
// The filter performs one multiply-accumulate per cycle over a circular
// sample buffer that it owns.
// Optional feature macro FIR_SAT_EN: when defined, the accumulator is shifted
// right arithmetically by OUT_SHIFT and then saturated to the signed output
// range. When undefined, the output is the low pDATA_WIDTH bits of the
// accumulator, which wraps on overflow.
`timescale 1ns/1ps

module fir_stream_engine #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int NUM_TAPS    = 11,
  parameter int OUT_SHIFT   = 0
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  // AXI4-Lite write
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  // AXI4-Lite read
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  // AXI-Stream in
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  // AXI-Stream out
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);

  localparam int IW = $clog2(NUM_TAPS);
  localparam int PW = 2 * pDATA_WIDTH;
  localparam int AW = PW + IW;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL    = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN     = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TAP0    = pADDR_WIDTH'(64);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TAP_END = pADDR_WIDTH'(64 + 4 * NUM_TAPS);
  localparam logic [IW-1:0]          LAST_IDX     = IW'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [pDATA_WIDTH-1:0] taps       [NUM_TAPS];
  logic [pDATA_WIDTH-1:0] sample_buf [NUM_TAPS];
  logic [pDATA_WIDTH-1:0] data_length;
  logic [pDATA_WIDTH-1:0] out_cnt;
  logic                   ap_start, ap_done, ap_idle;
  logic                   enter_done;

  logic [IW-1:0]          head, rd_ptr, mac_idx, clr_idx;
  logic signed [PW-1:0]   tap_ext, smp_ext, product;
  logic signed [AW-1:0]   acc, acc_next;
  logic [pDATA_WIDTH-1:0] out_value;

  // ---------------------------------------------------------------------
  // AXI4-Lite address decode
  // ---------------------------------------------------------------------
  logic                   wr_fire, wr_tap, wr_len, wr_start;
  logic [pADDR_WIDTH-1:0] wr_off, rd_off;
  logic [IW-1:0]          wr_tap_idx, rd_tap_idx;
  logic                   rd_fire, rd_tap;
  logic [pDATA_WIDTH-1:0] rd_value;

  // A write is taken only when the address and the data arrive together.
  assign wr_fire    = awvalid && wvalid;
  assign awready    = wr_fire;
  assign wready     = wr_fire;
  assign wr_off     = awaddr - ADDR_TAP0;
  assign wr_tap_idx = wr_off[IW+1:2];
  assign wr_tap     = wr_fire && ap_idle && (awaddr >= ADDR_TAP0) &&
                      (awaddr < ADDR_TAP_END) && (awaddr[1:0] == 2'b00);
  assign wr_len     = wr_fire && ap_idle && (awaddr == ADDR_LEN);
  assign wr_start   = wr_fire && ap_idle && (awaddr == ADDR_CTRL) && wdata[0];

  // Only one read is in flight: no new address is accepted while rdata is held.
  assign arready    = arvalid && !rvalid;
  assign rd_fire    = arvalid && arready;
  assign rd_off     = araddr - ADDR_TAP0;
  assign rd_tap_idx = rd_off[IW+1:2];
  assign rd_tap     = (araddr >= ADDR_TAP0) && (araddr < ADDR_TAP_END) &&
                      (araddr[1:0] == 2'b00);

  // Address bits outside the tap index and the ignored tlast are deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^{ss_tlast, wr_off[1:0], wr_off[pADDR_WIDTH-1:IW+2],
                         rd_off[1:0], rd_off[pADDR_WIDTH-1:IW+2]};

  // Read data mux; unmapped addresses return zero.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    rd_value = '0;
    if (araddr == ADDR_CTRL) begin
      rd_value = pDATA_WIDTH'({ap_idle, ap_done, ap_start});
    end else if (araddr == ADDR_LEN) begin
      rd_value = data_length;
    end else if (rd_tap) begin
      rd_value = taps[rd_tap_idx];
    end
  end

  // Read channel: capture the data on the address handshake and hold it until rready.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (rd_fire) begin
      rvalid <= 1'b1;
      rdata  <= rd_value;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

  // Control and status: start request, done/idle flags, and frame length.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      ap_start    <= 1'b0;
      ap_done     <= 1'b0;
      ap_idle     <= 1'b1;
      data_length <= '0;
    end else begin
      if (wr_len) begin
        data_length <= wdata;
      end
      if (state == S_IDLE && ap_start) begin
        ap_start <= 1'b0;
        ap_idle  <= 1'b0;
      end else if (wr_start) begin
        ap_start <= 1'b1;
      end
      // A done event wins over a status read that lands on the same edge.
      if (enter_done) begin
        ap_done <= 1'b1;
        ap_idle <= 1'b1;
      end else if (rd_fire && araddr == ADDR_CTRL) begin
        ap_done <= 1'b0;
      end
    end
  end

  // Coefficient register file: writable only while the engine is idle.
  // NOTE: taps and samples must read as zero straight after reset, so both arrays are flops with an explicit reset loop rather than an unreset RAM.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) taps[i] <= '0;
    end else if (wr_tap) begin
      taps[wr_tap_idx] <= wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Multiply-accumulate datapath
  // ---------------------------------------------------------------------
  // Both operands are sign-extended to full product width before multiplying.
  assign tap_ext  = PW'($signed(taps[mac_idx]));
  assign smp_ext  = PW'($signed(sample_buf[rd_ptr]));
  assign product  = tap_ext * smp_ext;
  assign acc_next = acc + AW'(product);

`ifdef FIR_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = AW'({1'b0, {(pDATA_WIDTH-1){1'b1}}});
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [AW-1:0] acc_shifted;

  // Scale the final sum, then clamp it to the signed output range.
  always_comb begin
    acc_shifted = acc_next >>> OUT_SHIFT;
    out_value   = acc_shifted[pDATA_WIDTH-1:0];
    if (acc_shifted > SAT_MAX) begin
      out_value = SAT_MAX[pDATA_WIDTH-1:0];
    end else if (acc_shifted < SAT_MIN) begin
      out_value = SAT_MIN[pDATA_WIDTH-1:0];
    end
  end
`else
  // OUT_SHIFT has no effect in the wrapping build; it appears here at weight zero.
  localparam int WRAP_LSB = 0 * OUT_SHIFT;
  assign out_value = acc_next[WRAP_LSB +: pDATA_WIDTH];
`endif

  // State register.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the stream handshake outputs.
  always_comb begin
    next_state = state;
    ss_tready  = 1'b0;
    sm_tvalid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ap_start) next_state = S_CLEAR;
      end
      S_CLEAR: begin
        if (clr_idx == LAST_IDX) begin
          next_state = (data_length == '0) ? S_DONE : S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        ss_tready = 1'b1;
        if (ss_tvalid) next_state = S_MAC;
      end
      S_MAC: begin
        if (mac_idx == LAST_IDX) next_state = S_OUT;
      end
      S_OUT: begin
        sm_tvalid = 1'b1;
        if (sm_tready) next_state = sm_tlast ? S_DONE : S_WAIT_IN;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign enter_done = (next_state == S_DONE) && (state != S_DONE);

  // Sample buffer, pointers, accumulator and the registered stream output.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) sample_buf[i] <= '0;
      head     <= '0;
      rd_ptr   <= '0;
      mac_idx  <= '0;
      clr_idx  <= '0;
      acc      <= '0;
      out_cnt  <= '0;
      sm_tdata <= '0;
      sm_tlast <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          clr_idx <= '0;
          head    <= '0;
          out_cnt <= '0;
        end
        S_CLEAR: begin
          sample_buf[clr_idx] <= '0;
          clr_idx             <= clr_idx + IW'(1);
        end
        S_WAIT_IN: begin
          if (ss_tvalid) begin
            // The newest sample lands at head; the MAC walks backwards from it.
            sample_buf[head] <= ss_tdata;
            rd_ptr           <= head;
            head             <= (head == LAST_IDX) ? '0 : head + IW'(1);
            mac_idx          <= '0;
            acc              <= '0;
          end
        end
        S_MAC: begin
          acc     <= acc_next;
          mac_idx <= mac_idx + IW'(1);
          rd_ptr  <= (rd_ptr == '0) ? LAST_IDX : rd_ptr - IW'(1);
          if (mac_idx == LAST_IDX) begin
            sm_tdata <= out_value;
            sm_tlast <= (out_cnt + pDATA_WIDTH'(1)) == data_length;
          end
        end
        S_OUT: begin
          if (sm_tready) out_cnt <= out_cnt + pDATA_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_engine.sv
// Self-checking bench for fir_stream_engine.
// The reference model is a direct convolution of the programmed taps with the
// samples of the current frame. The buffer is cleared at the start of every
// frame, so samples before the frame count as zero.
`timescale 1ns/1ps

module tb_fir_stream_engine;

  localparam int AWD = 12;
  localparam int DW  = 32;
  localparam int NT  = 11;
  localparam int OSH = 0;

  logic          axis_clk, axis_rst_n;
  logic          awvalid, awready, wvalid, wready;
  logic [AWD-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic          arvalid, arready, rvalid, rready;
  logic          ss_tvalid, ss_tready, ss_tlast;
  logic [DW-1:0] ss_tdata, sm_tdata;
  logic          sm_tvalid, sm_tready, sm_tlast;

  fir_stream_engine #(
    .pADDR_WIDTH(AWD), .pDATA_WIDTH(DW), .NUM_TAPS(NT), .OUT_SHIFT(OSH)
  ) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_taps [NT];
  logic [31:0] m_x [$];
  logic [31:0] got_y [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // y[k] = sum_i tap[i] * x[k-i], evaluated wide enough never to overflow.
  function automatic logic [31:0] model_y(input int k);
    logic signed [127:0] sum, a, b, sh;
    sum = '0;
    for (int i = 0; i < NT; i++) begin
      if (k - i >= 0) begin
        a   = $signed(m_taps[i]);
        b   = $signed(m_x[k-i]);
        sum = sum + a * b;
      end
    end
`ifdef FIR_SAT_EN
    sh = sum >>> OSH;
    if (sh > 128'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (sh < -128'sh80000000) return 32'h80000000;
    return sh[31:0];
`else
    sh = sum;
    return sh[31:0];
`endif
  endfunction

  function automatic logic [31:0] rand_word();
    int unsigned sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return 32'(int'($urandom_range(0, 2000)) - 1000);
    if (sel == 1) return 32'($urandom);
    if (sel == 2) return 32'(int'($urandom_range(0, 20)) - 10);
    return 32'h0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge axis_clk);
    #1;
  endtask

  task automatic axi_write(input logic [AWD-1:0] addr, input logic [31:0] data);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge axis_clk);
      ok = awready && wready;
      @(posedge axis_clk);
      #1;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!ok) check("aw_timeout", 64'(ok), 64'd1);
  endtask

  task automatic axi_read(input logic [AWD-1:0] addr, output logic [31:0] data);
    bit ok, got;
    int n;
    ok = 1'b0; got = 1'b0; n = 0; data = '0;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (!ok && n < 50) begin
      @(negedge axis_clk);
      ok = arready;
      @(posedge axis_clk);
      #1;
      n++;
    end
    arvalid = 1'b0;
    n = 0;
    while (ok && !got && n < 50) begin
      @(negedge axis_clk);
      if (rvalid) begin
        got  = 1'b1;
        data = rdata;
      end
      @(posedge axis_clk);
      #1;
      n++;
    end
    rready = 1'b0;
    if (!got) check("ar_timeout", 64'(got), 64'd1);
  endtask

  task automatic write_tap(input int i, input logic [31:0] v);
    axi_write(AWD'(64 + 4 * i), v);
    m_taps[i] = v;
  endtask

  task automatic send_sample(input logic [31:0] data, input int stall, output bit ok);
    int n;
    ok = 1'b0; n = 0;
    if (stall > 0) tick(stall);
    ss_tdata = data; ss_tvalid = 1'b1;
    while (!ok && n < 300) begin
      @(negedge axis_clk);
      ok = ss_tready;
      @(posedge axis_clk);
      #1;
      n++;
    end
    ss_tvalid = 1'b0;
    if (!ok) check("ss_timeout", 64'(ok), 64'd1);
  endtask

  task automatic recv_output(input int stall, output logic [31:0] data, output logic last,
                             output bit ok);
    bit seen;
    logic [32:0] first;
    int n;
    ok = 1'b0; seen = 1'b0; first = '0; n = 0; data = '0; last = 1'b0;
    sm_tready = 1'b0;
    repeat (stall) begin
      @(negedge axis_clk);
      if (sm_tvalid && !seen) begin
        seen  = 1'b1;
        first = {sm_tlast, sm_tdata};
      end
      @(posedge axis_clk);
      #1;
    end
    sm_tready = 1'b1;
    while (!ok && n < 300) begin
      @(negedge axis_clk);
      if (sm_tvalid) begin
        ok   = 1'b1;
        data = sm_tdata;
        last = sm_tlast;
      end
      @(posedge axis_clk);
      #1;
      n++;
    end
    sm_tready = 1'b0;
    if (!ok) check("sm_timeout", 64'(ok), 64'd1);
    if (ok && seen) check("sm_hold_stable", 64'({last, data}), 64'(first));
  endtask

  task automatic start_frame(input int len);
    axi_write(AWD'(16), 32'(len));
    axi_write(AWD'(0), 32'h1);
    m_x.delete();
    got_y.delete();
  endtask

  function automatic int pick_stall(input int smax);
    if (smax <= 0) return 0;
    if ($urandom_range(0, 2) == 0) return int'($urandom_range(1, smax));
    return 0;
  endfunction

  task automatic stream_frame(input int n, input int smax);
    fork
      begin
        for (int k = 0; k < n; k++) begin
          bit ok;
          send_sample(m_x[k], pick_stall(smax), ok);
          if (!ok) break;
        end
      end
      begin
        for (int k = 0; k < n; k++) begin
          logic [31:0] d;
          logic        l;
          bit          ok;
          recv_output(pick_stall(smax), d, l, ok);
          if (!ok) break;
          got_y.push_back(d);
          check($sformatf("y[%0d]", k), 64'(d), 64'(model_y(k)));
          check($sformatf("tlast[%0d]", k), 64'(l), 64'(k == n - 1));
        end
      end
    join
  endtask

  task automatic finish_frame();
    logic [31:0] c;
    int n;
    n = 0;
    axi_read(AWD'(0), c);
    while (!c[1] && n < 20) begin
      axi_read(AWD'(0), c);
      n++;
    end
    check("ctrl_done", 64'(c), 64'h6);
    axi_read(AWD'(0), c);
    check("ctrl_done_cleared", 64'(c), 64'h4);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got=stuck expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    bit ok;
    logic [31:0] d;
    logic l;

    axis_rst_n = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0;
    ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0; sm_tready = 0;
    for (int i = 0; i < NT; i++) m_taps[i] = '0;
    tick(3);
    check("reset_outputs",
          64'({sm_tvalid, ss_tready, sm_tlast, rvalid, awready, wready, arready}), 64'd0);
    check("reset_data", {sm_tdata, rdata}, 64'd0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    tick(2);

    // Register map after reset
    axi_read(AWD'(0), r);    check("ctrl_reset", 64'(r), 64'h4);
    axi_read(AWD'(16), r);   check("len_reset", 64'(r), 64'h0);
    axi_read(AWD'(64 + 20), r); check("tap5_reset", 64'(r), 64'h0);

    // Readback and unmapped addresses
    write_tap(3, 32'hDEADBEEF);
    axi_read(AWD'('h4C), r); check("tap3_readback", 64'(r), 64'hDEADBEEF);
    axi_write(AWD'('h20), 32'h55);
    axi_read(AWD'('h20), r); check("unmapped_read", 64'(r), 64'h0);
    axi_write(AWD'(16), 32'd7);
    axi_read(AWD'(16), r);   check("len_readback", 64'(r), 64'd7);

    // Zero-length frame: clear then done, no stream traffic
    axi_write(AWD'(16), 32'd0);
    axi_write(AWD'(0), 32'h1);
    tick(NT + 1);
    axi_read(AWD'(0), r);    check("len0_done", 64'(r), 64'h6);
    check("len0_no_stream", 64'({ss_tready, sm_tvalid}), 64'd0);
    axi_read(AWD'(0), r);    check("len0_done_cleared", 64'(r), 64'h4);

    // Impulse: taps 1..11 give y = 1..11
    for (int i = 0; i < NT; i++) write_tap(i, 32'(i + 1));
    start_frame(NT);
    for (int k = 0; k < NT; k++) m_x.push_back((k == 0) ? 32'd1 : 32'd0);
    stream_frame(NT, 0);
    for (int k = 0; k < got_y.size(); k++)
      check($sformatf("impulse[%0d]", k), 64'(got_y[k]), 64'(k + 1));
    finish_frame();

    // Tap and length writes while running are dropped
    for (int i = 0; i < NT; i++) write_tap(i, rand_word());
    start_frame(3);
    tick(NT + 4);
    axi_write(AWD'(64), ~m_taps[0]);
    axi_write(AWD'(16), 32'd99);
    axi_read(AWD'(64), r);   check("tap0_write_dropped", 64'(r), 64'(m_taps[0]));
    axi_read(AWD'(16), r);   check("len_write_dropped", 64'(r), 64'd3);
    axi_read(AWD'(0), r);    check("ctrl_busy", 64'(r), 64'h0);
    for (int k = 0; k < 3; k++) m_x.push_back(rand_word());
    stream_frame(3, 2);
    finish_frame();

    // Long random frame with stalls on both streams
    for (int i = 0; i < NT; i++) write_tap(i, rand_word());
    start_frame(600);
    for (int k = 0; k < 600; k++) m_x.push_back(rand_word());
    stream_frame(600, 3);
    finish_frame();

    // Overflow corner
    for (int i = 0; i < NT; i++) write_tap(i, 32'h7FFFFFFF);
    start_frame(NT);
    for (int k = 0; k < NT; k++) m_x.push_back(32'h7FFFFFFF);
    stream_frame(NT, 1);
    if (got_y.size() == NT) begin
`ifdef FIR_SAT_EN
      check("overflow_last", 64'(got_y[NT-1]), 64'h7FFFFFFF);
`else
      check("overflow_last", 64'(got_y[NT-1]), 64'(NT));
`endif
    end
    finish_frame();

    // Reset in the middle of a frame
    for (int i = 0; i < NT; i++) write_tap(i, rand_word() | 32'h1);
    start_frame(10);
    for (int k = 0; k < 10; k++) m_x.push_back(rand_word());
    for (int k = 0; k < 5; k++) begin
      send_sample(m_x[k], 0, ok);
      recv_output(0, d, l, ok);
      check($sformatf("pre_reset_y[%0d]", k), 64'(d), 64'(model_y(k)));
    end
    send_sample(m_x[5], 0, ok);
    tick(3);
    #2 axis_rst_n = 1'b0;
    #1;
    check("midreset_outputs",
          64'({sm_tvalid, ss_tready, sm_tlast, rvalid, awready, arready}), 64'd0);
    check("midreset_data", {sm_tdata, rdata}, 64'd0);
    tick(NT + 4);
    check("midreset_no_output", 64'(sm_tvalid), 64'd0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    for (int i = 0; i < NT; i++) m_taps[i] = '0;
    tick(2);
    axi_read(AWD'(0), r);    check("midreset_ctrl", 64'(r), 64'h4);
    axi_read(AWD'(64), r);   check("midreset_tap0", 64'(r), 64'h0);
    for (int i = 0; i < NT; i++) write_tap(i, rand_word());
    start_frame(20);
    for (int k = 0; k < 20; k++) m_x.push_back(rand_word());
    stream_frame(20, 2);
    finish_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
